// File: rtl/aq_spsram_256x59_ctrl_if.sv
// Request/response handshake bundle between a client and the 256x59 SRAM initiator.
// The client drives requests and consumes responses; the controller is the slave side.
interface aq_spsram_256x59_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 59
);
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_data;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_data
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_data
    );
endinterface

// File: rtl/aq_spsram_256x59_ctrl.sv
// Single-port SRAM initiator: valid/ready requests to CEN/GWEN/WEN cycles, reads returned via 2-entry FIFO.
// Define AQ_SPSRAM_CTRL_INIT_EN to sweep the array to INIT_VAL after reset.
//
// state   | meaning
// ST_PEND | in or just out of reset, SRAM idle, no requests
// ST_INIT | sweeping INIT_VAL into address init_cnt_q
// ST_RUN  | serving requests
module aq_spsram_256x59_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 59,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    aq_spsram_256x59_ctrl_if.slave bus,
    output logic                  init_done_o,
    output logic [ADDR_WIDTH-1:0] a_o,
    output logic                  cen_o,
    output logic                  gwen_o,
    output logic [DATA_WIDTH-1:0] wen_o,
    output logic [DATA_WIDTH-1:0] d_o,
    input  logic [DATA_WIDTH-1:0] q_i
);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {ST_PEND, ST_INIT, ST_RUN} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   init_cnt_q;
    logic                    init_done_q;
    logic [ADDR_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   d_q;
    logic                    rd_inflight_q;
    logic [1:0]              fifo_cnt_q;
    logic [DATA_WIDTH-1:0]   fifo_head_q;
    logic [DATA_WIDTH-1:0]   fifo_tail_q;

    logic                    rsp_pop;
    logic                    rsp_push;
    logic [2:0]              occ;
    logic                    credit_ok;
    logic                    req_acc;
    logic                    rd_acc;

    // Outstanding reads after this cycle's pop; one more may be accepted only if it still fits.
    assign rsp_pop   = bus.rsp_vld & bus.rsp_rdy;
    assign rsp_push  = rd_inflight_q;
    assign occ       = 3'(fifo_cnt_q) + 3'(rd_inflight_q) - 3'(rsp_pop);
    assign credit_ok = (occ <= 3'd1);

    assign bus.req_rdy  = init_done_q & (bus.req_wr | credit_ok);
    assign bus.rsp_vld  = (fifo_cnt_q != 2'd0);
    assign bus.rsp_data = fifo_head_q;
    assign init_done_o  = init_done_q;

    assign req_acc = bus.req_vld & bus.req_rdy;
    assign rd_acc  = req_acc & ~bus.req_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_PEND;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PEND: begin
`ifdef AQ_SPSRAM_CTRL_INIT_EN
                    state_q     <= ST_INIT;
`else
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
`endif
                end
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + CNT_ONE;
                    if (init_cnt_q == '1) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // A/D keep their last driven value when the SRAM is not selected.
    always_comb begin
        cen_o  = 1'b1;
        gwen_o = 1'b1;
        wen_o  = '1;
        a_o    = a_q;
        d_o    = d_q;
        if (state_q == ST_INIT) begin
            cen_o  = 1'b0;
            gwen_o = 1'b0;
            wen_o  = '0;
            a_o    = init_cnt_q;
            d_o    = INIT_VAL;
        end else if (req_acc) begin
            cen_o = 1'b0;
            a_o   = bus.req_addr;
            if (bus.req_wr) begin
                gwen_o = 1'b0;
                wen_o  = ~bus.req_wmask;
                d_o    = bus.req_wdata;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q           <= '0;
            d_q           <= '0;
            rd_inflight_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            fifo_head_q   <= '0;
            fifo_tail_q   <= '0;
        end else begin
            a_q           <= a_o;
            d_q           <= d_o;
            rd_inflight_q <= rd_acc;
            case ({rsp_push, rsp_pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) fifo_head_q <= q_i;
                    else                    fifo_tail_q <= q_i;
                    fifo_cnt_q <= fifo_cnt_q + 2'd1;
                end
                2'b01: begin
                    fifo_head_q <= fifo_tail_q;
                    fifo_cnt_q  <= fifo_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fifo_head_q <= q_i;
                    end else begin
                        fifo_head_q <= fifo_tail_q;
                        fifo_tail_q <= q_i;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aq_spsram_256x59_ctrl.sv
// Bench for aq_spsram_256x59_ctrl: behavioural SRAM plus a transaction-level memory/response model.
module tb_aq_spsram_256x59_ctrl;
    localparam logic [58:0] INIT_VAL = '0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done, cen, gwen;
    logic [7:0]  sram_a;
    logic [58:0] wen, d, q;

    always #5 clk = ~clk;

    aq_spsram_256x59_ctrl_if #(.AW(8), .DW(59)) bus ();

    aq_spsram_256x59_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(59), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .init_done_o(init_done),
        .a_o(sram_a), .cen_o(cen), .gwen_o(gwen), .wen_o(wen), .d_o(d), .q_i(q)
    );

    logic [58:0] sram_mem [256];
    always @(posedge clk) begin
        if (!cen) begin
            if (!gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & wen) | (d & ~wen);
            else       q <= sram_mem[sram_a];
        end
    end

    int          tests = 0;
    int          fails = 0;
    logic [58:0] ref_mem [256];
    logic [58:0] exp_q [$];

    function automatic logic [58:0] rnd59();
        return 59'({$urandom(), $urandom()});
    endfunction

    task automatic set_idle();
        bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_rdy = 1'b0;
    endtask

    // One clock cycle of stimulus; reports transfer/pop and advances the reference model.
    task automatic cyc(input logic v, input logic wr, input logic [7:0] ad,
                       input logic [58:0] wd, input logic [58:0] wm, input logic rr,
                       output logic acc, output logic pop,
                       output logic [58:0] pd, output logic [58:0] pexp);
        @(negedge clk);
        bus.req_vld = v; bus.req_wr = wr; bus.req_addr = ad;
        bus.req_wdata = wd; bus.req_wmask = wm; bus.rsp_rdy = rr;
        #1;
        acc  = v & bus.req_rdy;
        pop  = bus.rsp_vld & rr;
        pd   = bus.rsp_data;
        pexp = 'x;
        if (pop && exp_q.size() > 0) pexp = exp_q.pop_front();
        if (acc) begin
            if (wr) ref_mem[ad] = (ref_mem[ad] & ~wm) | (wd & wm);
            else    exp_q.push_back(ref_mem[ad]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.rsp_rdy = 1'b1;
        #1;
        tests++;
        if (cen !== 1'b1 || gwen !== 1'b1 || wen !== '1) begin
            fails++; $display("FAIL reset_ctrl cen=%b gwen=%b wen=%h want 1 1 all-1", cen, gwen, wen);
        end
        tests++;
        if (sram_a !== 8'd0 || d !== 59'd0) begin
            fails++; $display("FAIL reset_addr_data a=%h d=%h want 0 0", sram_a, d);
        end
        tests++;
        if (init_done !== 1'b0 || bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b0) begin
            fails++; $display("FAIL reset_hs init_done=%b req_rdy=%b rsp_vld=%b want 0 0 0",
                              init_done, bus.req_rdy, bus.rsp_vld);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (init_done !== 1'b0 || bus.req_rdy !== 1'b0 || cen !== 1'b1) begin
            fails++; $display("FAIL release_first init_done=%b req_rdy=%b cen=%b want 0 0 1",
                              init_done, bus.req_rdy, cen);
        end
    endtask

    task automatic test_init();
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        for (int n = 1; n <= 257; n++) begin
            @(negedge clk);
            if (n == 257) bus.req_vld = 1'b0;
            #1;
            tests++;
            if (n <= 256) begin
                if (cen !== 1'b0 || gwen !== 1'b0 || wen !== '0 || sram_a !== 8'(n - 1) ||
                    d !== INIT_VAL || bus.req_rdy !== 1'b0 || init_done !== 1'b0) begin
                    fails++; $display("FAIL sweep_%0d a=%h cen=%b gwen=%b d=%h rdy=%b done=%b want a=%h write",
                                      n, sram_a, cen, gwen, d, bus.req_rdy, init_done, 8'(n - 1));
                end
            end else if (init_done !== 1'b1 || bus.req_rdy !== 1'b1 || cen !== 1'b1) begin
                fails++; $display("FAIL sweep_done init_done=%b req_rdy=%b cen=%b want 1 1 1",
                                  init_done, bus.req_rdy, cen);
            end
        end
        for (int i = 0; i < 256; i++) ref_mem[i] = INIT_VAL;
`else
        @(negedge clk);
        bus.req_vld = 1'b0;
        #1;
        tests++;
        if (init_done !== 1'b1 || bus.req_rdy !== 1'b1 || cen !== 1'b1) begin
            fails++; $display("FAIL init_done init_done=%b req_rdy=%b cen=%b want 1 1 1",
                              init_done, bus.req_rdy, cen);
        end
`endif
        set_idle();
    endtask

    task automatic test_write_read();
        logic acc, pop; logic [58:0] pd, pe;
        cyc(1'b1, 1'b1, 8'd5, 59'h1234, '1, 1'b1, acc, pop, pd, pe);
        tests++;
        if (acc !== 1'b1 || cen !== 1'b0 || gwen !== 1'b0 || wen !== '0 || sram_a !== 8'd5 || d !== 59'h1234) begin
            fails++; $display("FAIL wr_pins acc=%b cen=%b gwen=%b wen=%h a=%h d=%h want 1 0 0 0 05 1234",
                              acc, cen, gwen, wen, sram_a, d);
        end
        cyc(1'b1, 1'b0, 8'd5, '0, '0, 1'b1, acc, pop, pd, pe);
        tests++;
        if (acc !== 1'b1 || cen !== 1'b0 || gwen !== 1'b1 || wen !== '1 || sram_a !== 8'd5) begin
            fails++; $display("FAIL rd_pins acc=%b cen=%b gwen=%b wen=%h a=%h want 1 0 1 all-1 05",
                              acc, cen, gwen, wen, sram_a);
        end
        cyc(1'b0, 1'b0, 8'd0, '0, '0, 1'b1, acc, pop, pd, pe);
        tests++;
        if (bus.rsp_vld !== 1'b0) begin
            fails++; $display("FAIL rd_lat1 rsp_vld=%b want 0", bus.rsp_vld);
        end
        cyc(1'b0, 1'b0, 8'd0, '0, '0, 1'b1, acc, pop, pd, pe);
        tests++;
        if (pop !== 1'b1 || pd !== 59'h1234 || pd !== pe) begin
            fails++; $display("FAIL rd_lat2 pop=%b data=%h want 1 %h", pop, pd, 59'h1234);
        end
        tests++;
        if (cen !== 1'b1 || gwen !== 1'b1 || wen !== '1 || sram_a !== 8'd5 || d !== 59'h1234) begin
            fails++; $display("FAIL idle_hold cen=%b gwen=%b a=%h d=%h want 1 1 05 1234", cen, gwen, sram_a, d);
        end
    endtask

    task automatic test_masked();
        logic acc, pop; logic [58:0] pd, pe; int got;
        cyc(1'b1, 1'b1, 8'd5, '1, 59'hFF, 1'b1, acc, pop, pd, pe);
        tests++;
        if (acc !== 1'b1 || wen !== ~59'hFF || gwen !== 1'b0) begin
            fails++; $display("FAIL mask_pins acc=%b wen=%h gwen=%b want 1 %h 0", acc, wen, gwen, ~59'hFF);
        end
        cyc(1'b1, 1'b0, 8'd5, '0, '0, 1'b1, acc, pop, pd, pe);
        got = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            cyc(1'b0, 1'b0, 8'd0, '0, '0, 1'b1, acc, pop, pd, pe);
            if (pop) begin
                got = 1;
                tests++;
                if (pd !== 59'h12FF || pd !== pe) begin
                    fails++; $display("FAIL mask_read data=%h want %h", pd, 59'h12FF);
                end
            end
        end
        tests++;
        if (got != 1) begin
            fails++; $display("FAIL mask_timeout responses=%0d want 1", got);
        end
    endtask

    task automatic test_stall();
        logic acc, pop, a3; logic [58:0] pd, pe; logic [58:0] r [3]; int got;
        for (int k = 0; k < 3; k++) begin
            r[k] = rnd59();
            cyc(1'b1, 1'b1, 8'(k + 1), r[k], '1, 1'b1, acc, pop, pd, pe);
        end
        cyc(1'b1, 1'b0, 8'd1, '0, '0, 1'b0, acc, pop, pd, pe);
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL stall_rd1 acc=%b want 1", acc); end
        cyc(1'b1, 1'b0, 8'd2, '0, '0, 1'b0, acc, pop, pd, pe);
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL stall_rd2 acc=%b want 1", acc); end
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) cyc(1'b1, 1'b0, 8'd3, '0, '0, 1'b0, acc, pop, pd, pe);
            else            cyc(1'b1, 1'b1, 8'd10, rnd59(), '1, 1'b0, acc, pop, pd, pe);
            tests++;
            if (acc !== (k % 2 == 1) || bus.rsp_vld !== 1'b1 || pd !== r[0] || exp_q.size() > 2) begin
                fails++; $display("FAIL stall_%0d acc=%b rsp_vld=%b data=%h outstanding=%0d want acc=%b 1 %h <=2",
                                  k, acc, bus.rsp_vld, pd, exp_q.size(), (k % 2 == 1), r[0]);
            end
        end
        got = 0; a3 = 1'b0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            cyc(!a3, 1'b0, 8'd3, '0, '0, 1'b1, acc, pop, pd, pe);
            if (acc) a3 = 1'b1;
            if (pop) begin
                tests++;
                if (pd !== r[got] || pd !== pe) begin
                    fails++; $display("FAIL stall_order_%0d data=%h want %h", got, pd, r[got]);
                end
                got++;
            end
        end
        tests++;
        if (got != 3 || !a3) begin
            fails++; $display("FAIL stall_drain responses=%0d rd3_acc=%b want 3 1", got, a3);
        end
    endtask

    task automatic test_stream();
        logic acc, pop, v; logic [58:0] pd, pe; logic [58:0] sd [16];
        int got, first, last;
        for (int i = 0; i < 16; i++) begin
            sd[i] = rnd59();
            cyc(1'b1, 1'b1, 8'(i), sd[i], '1, 1'b1, acc, pop, pd, pe);
        end
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 24 && got < 16; c++) begin
            v = (c < 16);
            cyc(v, 1'b0, 8'(c), '0, '0, 1'b1, acc, pop, pd, pe);
            if (v) begin
                tests++;
                if (acc !== 1'b1) begin fails++; $display("FAIL stream_rdy_%0d acc=%b want 1", c, acc); end
            end
            if (pop) begin
                tests++;
                if (pd !== sd[got] || pd !== pe) begin
                    fails++; $display("FAIL stream_data_%0d data=%h want %h", got, pd, sd[got]);
                end
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        tests++;
        if (got != 16 || first != 2 || last != 17) begin
            fails++; $display("FAIL stream_timing responses=%0d first=%0d last=%0d want 16 2 17", got, first, last);
        end
    endtask

    task automatic test_random();
        logic acc, pop, v, wr, rr; logic [58:0] pd, pe; int ovf;
        ovf = 0;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            wr = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            cyc(v, wr, 8'($urandom_range(0, 15)), rnd59(), rnd59(), rr, acc, pop, pd, pe);
            if (pop) begin
                tests++;
                if (pd !== pe) begin fails++; $display("FAIL rand_%0d data=%h want %h", c, pd, pe); end
            end
            if (exp_q.size() > 2) ovf++;
        end
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 1'b0, 8'd0, '0, '0, 1'b1, acc, pop, pd, pe);
            if (pop) begin
                tests++;
                if (pd !== pe) begin fails++; $display("FAIL rand_drain data=%h want %h", pd, pe); end
            end
        end
        tests++;
        if (ovf != 0 || exp_q.size() != 0) begin
            fails++; $display("FAIL rand_overflow overflows=%0d left=%0d want 0 0", ovf, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, pop; logic [58:0] pd, pe;
        cyc(1'b1, 1'b0, 8'd1, '0, '0, 1'b0, acc, pop, pd, pe);
        cyc(1'b1, 1'b0, 8'd2, '0, '0, 1'b0, acc, pop, pd, pe);
        cyc(1'b0, 1'b0, 8'd0, '0, '0, 1'b0, acc, pop, pd, pe);
        tests++;
        if (bus.rsp_vld !== 1'b1) begin fails++; $display("FAIL midrd_fill rsp_vld=%b want 1", bus.rsp_vld); end
        rst = 1'b1;
        set_idle();
        #1;
        exp_q.delete();
        tests++;
        if (bus.rsp_vld !== 1'b0 || cen !== 1'b1 || init_done !== 1'b0) begin
            fails++; $display("FAIL midrd_rst rsp_vld=%b cen=%b init_done=%b want 0 1 0", bus.rsp_vld, cen, init_done);
        end
        @(negedge clk);
        rst = 1'b0;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        begin
            int found;
            found = 0;
            for (int c = 0; c < 300 && found == 0; c++) begin
                @(negedge clk); #1;
                if (cen === 1'b0 && sram_a === 8'd100) found = 1;
            end
            tests++;
            if (found == 0) begin fails++; $display("FAIL sweep_reach100 found=0 want 1"); end
            rst = 1'b1;
            #1;
            tests++;
            if (cen !== 1'b1 || sram_a !== 8'd0 || bus.rsp_vld !== 1'b0 || init_done !== 1'b0) begin
                fails++; $display("FAIL sweep_rst cen=%b a=%h rsp_vld=%b done=%b want 1 00 0 0",
                                  cen, sram_a, bus.rsp_vld, init_done);
            end
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk); #1;
            tests++;
            if (sram_a !== 8'd0 || cen !== 1'b0 || gwen !== 1'b0) begin
                fails++; $display("FAIL sweep_restart a=%h cen=%b gwen=%b want 00 0 0", sram_a, cen, gwen);
            end
            for (int c = 0; c < 300 && init_done !== 1'b1; c++) begin
                @(negedge clk); #1;
            end
            tests++;
            if (init_done !== 1'b1) begin fails++; $display("FAIL sweep_redone init_done=%b want 1", init_done); end
            for (int i = 0; i < 256; i++) ref_mem[i] = INIT_VAL;
            cyc(1'b1, 1'b0, 8'd1, '0, '0, 1'b1, acc, pop, pd, pe);
            found = 0;
            for (int c = 0; c < 6 && found == 0; c++) begin
                cyc(1'b0, 1'b0, 8'd0, '0, '0, 1'b1, acc, pop, pd, pe);
                if (pop) begin
                    found = 1;
                    tests++;
                    if (pd !== INIT_VAL || pd !== pe) begin
                        fails++; $display("FAIL sweep_value data=%h want %h", pd, INIT_VAL);
                    end
                end
            end
            tests++;
            if (found == 0) begin fails++; $display("FAIL sweep_value_timeout responses=0 want 1"); end
        end
`else
        @(negedge clk); #1;
        tests++;
        if (init_done !== 1'b1 || bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
            fails++; $display("FAIL midrd_recover init_done=%b rsp_vld=%b req_rdy=%b want 1 0 1",
                              init_done, bus.rsp_vld, bus.req_rdy);
        end
`endif
    endtask

    initial begin
        set_idle();
        test_reset();
        test_init();
        test_write_read();
        test_masked();
        test_stall();
        test_stream();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
